// File: rtl/utils_pkg.sv
// Shared types and sizing helpers for the utils arithmetic blocks.
package utils_pkg;

    // Sequential multiplier control state, 1-bit encoded.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mult_state_t;

    // Step counter width for a WORD_WIDTH-step operation.
    function automatic int unsigned cnt_width(input int unsigned word_width);
        return (word_width < 2) ? 1 : $clog2(word_width);
    endfunction

endpackage

// File: rtl/seq_multiplier_claa.sv
// Carry-lookahead adder, carry-in fixed at 0.
module seq_multiplier_claa #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   c;
    logic             term;

    assign g = x & y;
    assign p = x ^ y;

    // Each carry is the OR of every generate propagated through the bits above it.
    always_comb begin
        c    = '0;
        term = 1'b0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & p[k];
                end
                c[i+1] = c[i+1] | term;
            end
        end
    end

    assign sum  = p ^ c[WIDTH-1:0];
    assign cout = c[WIDTH];

endmodule

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add unsigned multiplier: WORD_WIDTH steps per product.
module seq_multiplier
    import utils_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [WORD_WIDTH-1:0]   a,
    input  logic [WORD_WIDTH-1:0]   b,
    output logic                    busy,
    output logic                    done,
    output logic [2*WORD_WIDTH-1:0] product
);

    localparam int unsigned CNT_W = cnt_width(WORD_WIDTH);

    mult_state_t state;
    mult_state_t state_next;

    logic [WORD_WIDTH-1:0]   mc;
    logic [WORD_WIDTH-1:0]   mq;
    logic [WORD_WIDTH:0]     hi;
    logic [CNT_W-1:0]        cnt;

    logic [WORD_WIDTH-1:0]   mc_next;
    logic [WORD_WIDTH-1:0]   mq_next;
    logic [WORD_WIDTH:0]     hi_next;
    logic [CNT_W-1:0]        cnt_next;
    logic                    busy_next;
    logic                    done_next;
    logic [2*WORD_WIDTH-1:0] product_next;

    logic [WORD_WIDTH-1:0]   addend;
    logic [WORD_WIDTH-1:0]   add_sum;
    logic                    add_cout;
    logic [WORD_WIDTH:0]     sum_full;
    logic                    last_step;

    assign addend    = mq[0] ? mc : '0;
    assign last_step = (cnt == CNT_W'(WORD_WIDTH - 1));

    seq_multiplier_claa #(
        .WIDTH (WORD_WIDTH)
    ) u_claa (
        .x    (hi[WORD_WIDTH-1:0]),
        .y    (addend),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // hi[WORD_WIDTH] is always clear before the add, so OR-ing it in is exact.
    assign sum_full = {add_cout | hi[WORD_WIDTH], add_sum};

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: accept a start in IDLE, return after the final step.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start)     state_next = RUN;
            RUN:  if (last_step) state_next = IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        mc_next      = mc;
        mq_next      = mq;
        hi_next      = hi;
        cnt_next     = cnt;
        product_next = product;
        done_next    = 1'b0;
        busy_next    = (state_next == RUN);
        case (state)
            IDLE: begin
                if (start) begin
                    mc_next  = a;
                    mq_next  = b;
                    hi_next  = '0;
                    cnt_next = '0;
                end
            end
            RUN: begin
                hi_next  = {1'b0, sum_full[WORD_WIDTH:1]};
                mq_next  = {sum_full[0], mq[WORD_WIDTH-1:1]};
                cnt_next = cnt + CNT_W'(1);
                if (last_step) begin
                    product_next = {sum_full[WORD_WIDTH:1], sum_full[0], mq[WORD_WIDTH-1:1]};
                    done_next    = 1'b1;
                end
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mc      <= '0;
            mq      <= '0;
            hi      <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            mc      <= mc_next;
            mq      <= mq_next;
            hi      <= hi_next;
            cnt     <= cnt_next;
            busy    <= busy_next;
            done    <= done_next;
            product <= product_next;
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier against a cycle-level arithmetic model.
module tb_seq_multiplier;

    localparam int unsigned W = 8;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int unsigned    n_pass;
    int unsigned    n_total;
    logic [2*W-1:0] exp_prev;

    seq_multiplier #(
        .WORD_WIDTH (W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // One multiplication; optionally inject an ignored start at step ignore_at.
    task automatic run(input logic [W-1:0] ra, input logic [W-1:0] rb,
                       input int ignore_at, input bit check_after);
        logic [2*W-1:0] expv;
        expv  = (2*W)'(ra) * (2*W)'(rb);
        start = 1'b1;
        a     = ra;
        b     = rb;
        tick();
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        for (int k = 0; k < int'(W); k++) begin
            check("busy_run", (2*W)'(busy), 1);
            check("done_run", (2*W)'(done), 0);
            check("prod_hold", product, exp_prev);
            if (k == ignore_at) begin
                start = 1'b1;
                a     = W'($urandom);
                b     = W'($urandom);
            end
            tick();
            start = 1'b0;
        end
        check("busy_done", (2*W)'(busy), 0);
        check("done_pulse", (2*W)'(done), 1);
        check("product", product, expv);
        exp_prev = expv;
        if (check_after) begin
            tick();
            check("done_clear", (2*W)'(done), 0);
            check("busy_idle", (2*W)'(busy), 0);
            check("prod_stable", product, exp_prev);
        end
    endtask

    initial begin
        n_pass   = 0;
        n_total  = 0;
        exp_prev = '0;
        rst_n    = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;

        // Reset for two cycles.
        tick();
        tick();
        check("rst_busy", (2*W)'(busy), 0);
        check("rst_done", (2*W)'(done), 0);
        check("rst_product", product, 0);
        rst_n = 1'b1;
        tick();

        // Basic and extremes.
        run(8'd13, 8'd11, -1, 1'b1);
        run(8'd255, 8'd255, -1, 1'b1);
        run(8'd0, 8'd200, -1, 1'b1);
        run(8'd1, 8'd255, -1, 1'b1);
        run(8'd128, 8'd2, -1, 1'b1);

        // Start during busy is ignored; no second done.
        run(8'd7, 8'd9, 2, 1'b0);
        for (int k = 0; k < int'(W) + 2; k++) begin
            tick();
            check("no_second_done", (2*W)'(done), 0);
            check("no_restart", (2*W)'(busy), 0);
        end
        check("ignored_prod", product, 16'd63);

        // Back-to-back: second start in the done cycle.
        run(8'd3, 8'd5, -1, 1'b0);
        run(8'd6, 8'd7, -1, 1'b1);

        // Reset mid-run aborts; start is ignored during the reset cycle.
        start = 1'b1;
        a     = 8'd200;
        b     = 8'd3;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        start = 1'b1;
        a     = 8'd5;
        b     = 8'd5;
        tick();
        rst_n = 1'b1;
        start = 1'b0;
        check("abort_busy", (2*W)'(busy), 0);
        check("abort_done", (2*W)'(done), 0);
        check("abort_product", product, 0);
        exp_prev = '0;
        for (int k = 0; k < int'(W) + 2; k++) begin
            tick();
            check("abort_no_done", (2*W)'(done), 0);
            check("abort_no_busy", (2*W)'(busy), 0);
        end
        run(8'd10, 8'd10, -1, 1'b1);

        // Random operands, random ignored starts and back-to-back chaining.
        for (int n = 0; n < 24; n++) begin
            run(W'($urandom), W'($urandom),
                ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, W - 1)) : -1,
                $urandom_range(0, 1) == 1);
        end
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
